// File: rtl/clk_div_gen_pkg.sv
// Shared types and constants for the multi-channel clock-waveform generator.
// Channel settings are carried at CNT_W_MAX width so any CNT_W up to 16 fits.
package clk_div_gen_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int CNT_W_MAX  = 16;
  localparam int MIN_PERIOD = 2;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] per;
    logic [CNT_W_MAX-1:0] high;
    logic                 en;
  } chan_cfg_t;

  // A disable carries no timing, so its period/high are don't-care.
  function automatic logic cfg_legal(input logic [CNT_W_MAX-1:0] per,
                                     input logic [CNT_W_MAX-1:0] high,
                                     input logic                 en);
    return !en || ((per >= CNT_W_MAX'(MIN_PERIOD)) && (high != '0) && (high < per));
  endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Configuration write port of clk_div_gen: write strobe, channel, settings and reject pulse.
// The master drives writes; the slave answers with cfg_err one cycle after a rejected write.
interface clk_div_gen_if
  import clk_div_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_en;
  logic             cfg_err;

  modport master (output cfg_we, cfg_ch, cfg_period, cfg_high, cfg_en, input cfg_err);
  modport slave  (input cfg_we, cfg_ch, cfg_period, cfg_high, cfg_en, output cfg_err);

endinterface

// File: rtl/clk_div_chan.sv
// One waveform channel: shadow/active settings, period counter, registered clk_out/tick.
// New settings apply one edge after the write when idle, else at the end of the running period.
module clk_div_chan
  import clk_div_gen_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr,
  input  chan_cfg_t wr_cfg,
  output logic      clk_out,
  output logic      tick,
  output logic      active
);

  localparam logic [CNT_W_MAX-1:0] ONE = CNT_W_MAX'(1);

  chan_cfg_t            act_q, act_d;
  chan_cfg_t            shd_q, shd_d;
  logic                 pend_q, pend_d;
  logic [CNT_W_MAX-1:0] cnt_q, cnt_d;
  logic                 last, apply;
  logic                 clk_d, tick_d;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = '0;
    last   = act_q.en && (cnt_q == act_q.per - ONE);
    apply  = pend_q && (!act_q.en || last);
    if (act_q.en && !last) cnt_d = cnt_q + ONE;
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      cnt_d  = '0;
    end
    // A write coinciding with an apply lands after it, so it waits for the next boundary.
    if (wr) begin
      shd_d  = wr_cfg;
      pend_d = 1'b1;
    end
    clk_d  = act_d.en && (cnt_d < act_d.high);
    tick_d = act_d.en && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= '0;
      shd_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_out <= clk_d;
      tick    <= tick_d;
    end
  end

  assign active = act_q.en;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock-waveform generator with glitch-free reconfiguration.
// Outputs are registered; cfg_err pulses the cycle after a rejected write; no backpressure.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              clk,
  input  logic              rst_n,
  clk_div_gen_if.slave      cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] active
);

  chan_cfg_t wr_cfg;
  logic      ch_ok;
  logic      legal;

  assign wr_cfg = '{per:  CNT_W_MAX'(cfg.cfg_period),
                    high: CNT_W_MAX'(cfg.cfg_high),
                    en:   cfg.cfg_en};
  assign ch_ok  = int'(cfg.cfg_ch) < NUM_CH;
  assign legal  = ch_ok && cfg_legal(wr_cfg.per, wr_cfg.high, wr_cfg.en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg.cfg_err <= 1'b0;
    else        cfg.cfg_err <= cfg.cfg_we && !legal;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg.cfg_we && legal && (cfg.cfg_ch == CH_W'(i));

    clk_div_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr),
      .wr_cfg  (wr_cfg),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .active  (active[i])
    );
  end

endmodule
